axis_moving_average: RTL and testbench
======================================

AXIS_MOVING_AVERAGE -- requirements
Module: axis_moving_average

Interface
REQ-001 Parameter DATA_WIDTH, default 24, SHALL set the signed two's-complement sample width.
REQ-002 Parameter LOG2_TAPS, default 3, SHALL set the window length to 2^LOG2_TAPS samples per channel; legal range is 1..6.
REQ-003 clk  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 reset  in  1  SHALL be the synchronous, active-high reset.
REQ-005 enable  in  1  SHALL select filtered output (1) or bypass (0), sampled per accepted beat.
REQ-006 s_axis_data  in  DATA_WIDTH  SHALL carry the input sample.
REQ-007 s_axis_valid, s_axis_ready  in/out  1 each  SHALL form the input handshake.
REQ-008 s_axis_last  in  1  SHALL mark the channel: 0 = left, 1 = right.
REQ-009 m_axis_data  out  DATA_WIDTH  SHALL carry the output sample.
REQ-010 m_axis_valid, m_axis_ready  out/in  1 each  SHALL form the output handshake.
REQ-011 m_axis_last  out  1  SHALL equal the s_axis_last of the beat that produced the output.

Function
REQ-012 The FSM SHALL have two states: CLEAR and RUN.
REQ-013 CLEAR SHALL write zero to one history entry of both channels per cycle for 2^LOG2_TAPS cycles, then go to RUN.
REQ-014 s_axis_ready SHALL be 0 in CLEAR.
REQ-015 In RUN, s_axis_ready SHALL equal (!m_axis_valid || m_axis_ready).
REQ-016 A beat SHALL be accepted when s_axis_valid && s_axis_ready.
REQ-017 Each channel SHALL keep a history of 2^LOG2_TAPS samples and a signed accumulator of DATA_WIDTH+LOG2_TAPS bits.
REQ-018 A single write pointer SHALL be shared by both channels.
REQ-019 On an accepted beat of channel c with sample x, the block SHALL set acc_c <= acc_c - hist_c[ptr] + x and hist_c[ptr] <= x.
REQ-020 The output data SHALL be (acc_c - hist_c[ptr] + x) arithmetically shifted right by LOG2_TAPS, which floors toward minus infinity.
REQ-021 The accumulator SHALL never overflow, because its width bounds the sum by construction; no saturation is required.
REQ-022 With enable = 0, the output SHALL be x unchanged, while the history and accumulator still update so that toggling enable produces no transient.
REQ-023 The pointer SHALL increment, modulo 2^LOG2_TAPS, only on an accepted beat with s_axis_last = 1.
REQ-024 Consecutive left beats SHALL each update the left history at the same pointer, overwriting; the block SHALL NOT attempt resynchronisation.
REQ-025 The output SHALL be registered with a latency of exactly one cycle from acceptance to m_axis_valid = 1.
REQ-026 m_axis_data and m_axis_last SHALL stay stable while m_axis_valid && !m_axis_ready.
REQ-027 When output and input handshakes occur in the same cycle, the new beat SHALL replace the old one and m_axis_valid SHALL stay 1.
REQ-028 Full throughput SHALL be one beat per cycle when m_axis_ready is held 1.

Reset
REQ-029 While reset = 1, the block SHALL hold state CLEAR with pointer 0, both accumulators 0, m_axis_valid 0, m_axis_data 0, m_axis_last 0, and s_axis_ready 0.
REQ-030 After reset deasserts, the clear sweep SHALL run to completion before the first acceptance, at the earliest 2^LOG2_TAPS cycles later.
REQ-031 Reset asserted mid-stream SHALL discard any pending output beat and restart the clear sweep; no partial history may survive.

Structure
REQ-032 A shared package SHALL hold the FSM state enumeration, the default DATA_WIDTH/LOG2_TAPS constants, and the accumulator-width function DATA_WIDTH+LOG2_TAPS.
REQ-033 The history storage SHALL be a sub-module, avg_history_ram, of width 2*DATA_WIDTH and depth 2^LOG2_TAPS, with one combinational read port and one write port, holding both channels per address.
REQ-034 The top-level SHALL sit between axis_volume_controller and the I2S transmit stream, clocked by the AXIS clock.

Verification
REQ-035 With LOG2_TAPS = 3 and enable = 1, feeding 8 L/R pairs of 800/-800 with m_axis_ready = 1 SHALL produce left 100, 200, ..., 800 and right -100, ..., -800.
REQ-036 An impulse of left 1600 followed by zeros SHALL produce left 200 for exactly 8 left beats and then 0; a single left -8 SHALL produce -1, and a single left -1 SHALL produce -1 (floor).
REQ-037 Holding m_axis_ready = 0 for 5 cycles mid-stream SHALL keep m_axis_data and m_axis_last constant and hold s_axis_ready = 0, with no sample lost or duplicated once ready returns.
REQ-038 With enable = 0, input 12345 SHALL produce output 12345; switching to enable = 1 after 8 constant pairs of 12345 SHALL produce 12345 on the next beat.
REQ-039 Asserting reset for 1 cycle mid-stream SHALL drop m_axis_valid next cycle and hold s_axis_ready at 0 for 8 cycles, after which a fresh input of 800 SHALL produce 100.
REQ-040 Streaming random data with random valid/ready SHALL match a reference model beat-for-beat, including m_axis_last.

Source files
------------

// File: rtl/axis_moving_average_pkg.sv
// Shared types and sizing for the stereo moving-average filter.
package axis_moving_average_pkg;

   typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

   localparam int DEF_DATA_WIDTH = 24;
   localparam int DEF_LOG2_TAPS  = 3;

   // Accumulator holds the sum of 2^lt samples of dw bits without overflow.
   function automatic int acc_width(input int dw, input int lt);
      return dw + lt;
   endfunction

endpackage

// File: rtl/avg_history_ram.sv
// Sample history for both channels: {right, left} per address, async read, sync write.
module avg_history_ram #(
   parameter int DATA_WIDTH = 24,
   parameter int LOG2_TAPS  = 3
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [LOG2_TAPS-1:0]    waddr,
   input  logic [2*DATA_WIDTH-1:0] wdata,
   input  logic [LOG2_TAPS-1:0]    raddr,
   output logic [2*DATA_WIDTH-1:0] rdata
);

   logic [2*DATA_WIDTH-1:0] mem [2**LOG2_TAPS];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/axis_moving_average.sv
// Stereo boxcar average over 2^LOG2_TAPS samples per channel, AXI-Stream in/out,
// one-deep registered output; s_axis_last selects the channel (1 = right).
module axis_moving_average
   import axis_moving_average_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int LOG2_TAPS  = DEF_LOG2_TAPS
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] s_axis_data,
   input  logic                  s_axis_valid,
   output logic                  s_axis_ready,
   input  logic                  s_axis_last,
   output logic [DATA_WIDTH-1:0] m_axis_data,
   output logic                  m_axis_valid,
   input  logic                  m_axis_ready,
   output logic                  m_axis_last
);

   localparam int AW = acc_width(DATA_WIDTH, LOG2_TAPS);

   state_t                  state, state_nxt;
   logic [LOG2_TAPS-1:0]    clr_cnt, ptr, waddr;
   logic signed [AW-1:0]    acc_l, acc_r, acc_sel, old_ext, x_ext, sum;
   logic [DATA_WIDTH-1:0]   hist_old, avg;
   logic [2*DATA_WIDTH-1:0] rd_data, wr_data;
   logic                    we, accept;

   avg_history_ram #(.DATA_WIDTH(DATA_WIDTH), .LOG2_TAPS(LOG2_TAPS)) u_hist (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wr_data),
      .raddr (ptr),
      .rdata (rd_data)
   );

   assign s_axis_ready = !reset && (state == RUN) && (!m_axis_valid || m_axis_ready);
   assign accept       = s_axis_valid && s_axis_ready;

   // Running-sum update: drop the sample leaving the window, add the new one.
   assign hist_old = s_axis_last ? rd_data[2*DATA_WIDTH-1:DATA_WIDTH] : rd_data[DATA_WIDTH-1:0];
   assign acc_sel  = s_axis_last ? acc_r : acc_l;
   assign old_ext  = {{LOG2_TAPS{hist_old[DATA_WIDTH-1]}}, hist_old};
   assign x_ext    = {{LOG2_TAPS{s_axis_data[DATA_WIDTH-1]}}, s_axis_data};
   assign sum      = acc_sel - old_ext + x_ext;
   assign avg      = DATA_WIDTH'(sum >>> LOG2_TAPS);

   always_comb begin
      state_nxt = state;
      we        = 1'b0;
      waddr     = ptr;
      wr_data   = '0;
      case (state)
         CLEAR: begin
            we    = 1'b1;
            waddr = clr_cnt;
            if (clr_cnt == '1) state_nxt = RUN;
         end
         RUN: begin
            // Only the accepted channel's half changes; the other is written back.
            if (accept) begin
               we      = 1'b1;
               wr_data = s_axis_last ? {s_axis_data, rd_data[DATA_WIDTH-1:0]}
                                     : {rd_data[2*DATA_WIDTH-1:DATA_WIDTH], s_axis_data};
            end
         end
         default: state_nxt = CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= CLEAR;
         clr_cnt      <= '0;
         ptr          <= '0;
         acc_l        <= '0;
         acc_r        <= '0;
         m_axis_valid <= 1'b0;
         m_axis_data  <= '0;
         m_axis_last  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == CLEAR) clr_cnt <= clr_cnt + LOG2_TAPS'(1);
         if (accept) begin
            if (s_axis_last) begin
               acc_r <= sum;
               ptr   <= ptr + LOG2_TAPS'(1);
            end else begin
               acc_l <= sum;
            end
            m_axis_valid <= 1'b1;
            m_axis_data  <= enable ? avg : s_axis_data;
            m_axis_last  <= s_axis_last;
         end else if (m_axis_ready) begin
            m_axis_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axis_moving_average.sv
// Bench for axis_moving_average: window-sum reference model, directed cases, random streaming.
module tb_axis_moving_average;

   localparam int DW = 24;
   localparam int L  = 3;
   localparam int N  = 1 << L;

   logic          clk = 1'b0, reset = 1'b1, enable = 1'b1;
   logic          s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b1;
   logic [DW-1:0] s_data = '0;
   logic          s_ready, m_valid, m_last;
   logic [DW-1:0] m_data;

   int tests = 0, fails = 0;

   typedef struct {longint d; logic l;} beat_t;
   beat_t  exp_q[$];
   longint obs_q[$];
   longint hist[2][N];
   int     mptr;

   axis_moving_average #(.DATA_WIDTH(DW), .LOG2_TAPS(L)) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .s_axis_data  (s_data),
      .s_axis_valid (s_valid),
      .s_axis_ready (s_ready),
      .s_axis_last  (s_last),
      .m_axis_data  (m_data),
      .m_axis_valid (m_valid),
      .m_axis_ready (m_ready),
      .m_axis_last  (m_last)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input longint got, input longint exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endfunction

   function automatic longint floor_div(input longint a, input longint b);
      if (a >= 0) return a / b;
      return -((-a + b - 1) / b);
   endfunction

   function automatic void model_reset();
      for (int c = 0; c < 2; c++)
         for (int i = 0; i < N; i++) hist[c][i] = 0;
      mptr = 0;
      exp_q.delete();
   endfunction

   // Output is the floored mean of the channel's last N samples (or x when bypassed).
   function automatic void model_accept(input longint x, input logic l, input logic en);
      longint s;
      beat_t  b;
      int     c;
      c = l ? 1 : 0;
      hist[c][mptr] = x;
      s = 0;
      for (int i = 0; i < N; i++) s += hist[c][i];
      b.d = en ? floor_div(s, N) : x;
      b.l = l;
      exp_q.push_back(b);
      if (l) mptr = (mptr + 1) % N;
   endfunction

   function automatic longint obs_at(input int i);
      if (i < obs_q.size()) return obs_q[i];
      return 64'sd999999999;
   endfunction

   always @(negedge clk) begin
      if (!reset) begin
         if (m_valid && m_ready) begin
            obs_q.push_back(longint'($signed(m_data)));
            if (exp_q.size() == 0) begin
               check("unexpected_out", 1, 0);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               check("out_data", longint'($signed(m_data)), e.d);
               check("out_last", longint'(m_last), longint'(e.l));
            end
         end
         if (s_valid && s_ready)
            model_accept(longint'($signed(s_data)), s_last, enable);
      end
   end

   task automatic do_reset(input int cyc);
      int n;
      @(posedge clk); #1;
      reset = 1'b1; s_valid = 1'b0;
      repeat (cyc) @(posedge clk);
      #1;
      check("rst_m_valid", longint'(m_valid), 0);
      check("rst_m_data",  longint'(m_data), 0);
      check("rst_m_last",  longint'(m_last), 0);
      check("rst_s_ready", longint'(s_ready), 0);
      reset = 1'b0;
      model_reset();
      obs_q.delete();
      @(negedge clk);
      check("post_rst_m_valid", longint'(m_valid), 0);
      n = 0;
      while (!s_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      check("clear_cycles", n, N);
      @(posedge clk); #1;
   endtask

   // Leaves s_valid high on return so back-to-back calls stream at full rate.
   task automatic send(input longint x, input logic l, input logic en);
      int n;
      s_valid = 1'b1; s_data = DW'(x); s_last = l; enable = en;
      n = 0;
      @(negedge clk);
      while (!s_ready && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (n >= 100) check("send_timeout", 1, 0);
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int n;
      s_valid = 1'b0; m_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         n++;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      check("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      bit hs;
      model_reset();
      do_reset(3);

      // Step response: 8 pairs of +/-800 ramp in by 100 per beat.
      for (int k = 0; k < N; k++) begin
         send(800, 1'b0, 1'b1);
         send(-800, 1'b1, 1'b1);
      end
      drain();
      for (int k = 0; k < N; k++) begin
         check("step_left",  obs_at(2*k),   100*(k+1));
         check("step_right", obs_at(2*k+1), -100*(k+1));
      end

      // Impulse, then floor behaviour for small negatives.
      do_reset(1);
      send(1600, 1'b0, 1'b1); send(0, 1'b1, 1'b1);
      for (int k = 0; k < N; k++) begin
         send(0, 1'b0, 1'b1); send(0, 1'b1, 1'b1);
      end
      send(-8, 1'b0, 1'b1); send(0, 1'b1, 1'b1);
      for (int k = 0; k < N; k++) begin
         send(0, 1'b0, 1'b1); send(0, 1'b1, 1'b1);
      end
      send(-1, 1'b0, 1'b1); send(0, 1'b1, 1'b1);
      drain();
      for (int k = 0; k < N; k++) check("impulse_left", obs_at(2*k), 200);
      check("impulse_tail", obs_at(2*N), 0);
      check("neg8_left",    obs_at(2*N+2), -1);
      check("neg1_floor",   obs_at(4*N+4), -1);

      // Output stall: data held, input blocked, nothing lost.
      do_reset(1);
      send(800, 1'b0, 1'b1);
      m_ready = 1'b0; s_valid = 1'b1; s_data = DW'(-800); s_last = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stall_data",    longint'($signed(m_data)), 100);
         check("stall_last",    longint'(m_last), 0);
         check("stall_s_ready", longint'(s_ready), 0);
         check("stall_m_valid", longint'(m_valid), 1);
         @(posedge clk); #1;
      end
      m_ready = 1'b1;
      send(-800, 1'b1, 1'b1);
      drain();
      check("stall_count", obs_q.size(), 2);
      check("stall_right", obs_at(1), -100);

      // Bypass, then enable switch with a settled window.
      do_reset(1);
      for (int k = 0; k < N; k++) begin
         send(12345, 1'b0, 1'b0); send(12345, 1'b1, 1'b0);
      end
      send(12345, 1'b0, 1'b1);
      drain();
      check("bypass",      obs_at(0), 12345);
      check("enable_swap", obs_at(2*N), 12345);

      // Reset while an output beat is pending.
      send(800, 1'b0, 1'b1); send(800, 1'b1, 1'b1);
      m_ready = 1'b0;
      do_reset(1);
      m_ready = 1'b1;
      send(800, 1'b0, 1'b1);
      drain();
      check("after_reset", obs_at(0), 100);

      // Random traffic with random backpressure and channel order.
      do_reset(1);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         hs = s_valid && s_ready;
         @(posedge clk); #1;
         if (!s_valid || hs) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = DW'($urandom);
            s_last  = ($urandom_range(0, 5) < 3);
            enable  = ($urandom_range(0, 4) != 0);
         end
         m_ready = ($urandom_range(0, 3) != 0);
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end

endmodule
